// File: rtl/riscv_fifo_reader.sv
// riscv_fifo_reader: pop-side consumer for a show-ahead FIFO.
// Drains FIFO words into a 2-entry output buffer and re-presents them as a
// registered valid/ready stream; fifo_pop never depends on out_ready.
// Optional handshake counter (out_count) built when RISCV_FIFO_READER_STATS_EN is defined.
module riscv_fifo_reader #(
   parameter int unsigned DATA_W = 32
`ifdef RISCV_FIFO_READER_STATS_EN
   , parameter int unsigned STAT_W = 16
`endif
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic [DATA_W-1:0] fifo_data_out,
   input  logic              fifo_empty,
   output logic              fifo_pop,
   output logic              fifo_flush,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready
`ifdef RISCV_FIFO_READER_STATS_EN
   , output logic [STAT_W-1:0] out_count
`endif
);

   // Occupancy of the output buffer doubles as the FSM state.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] buf0_q, buf0_d;
   logic [DATA_W-1:0] buf1_q, buf1_d;
   logic              valid_d;
   logic              take;

   assign fifo_flush = flush;
   assign out_data   = buf0_q;
   assign take       = out_valid & out_ready;
   // Pop only when a slot is free; independent of out_ready by design.
   assign fifo_pop   = ~flush & ~fifo_empty & (state_q != TWO);

   // State, buffer slots and registered valid.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= EMPTY;
         buf0_q    <= '0;
         buf1_q    <= '0;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         buf0_q    <= buf0_d;
         buf1_q    <= buf1_d;
         out_valid <= valid_d;
      end
   end

   // Next-state and slot update; flush empties the buffer regardless of take.
   always_comb begin
      state_d = state_q;
      buf0_d  = buf0_q;
      buf1_d  = buf1_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (fifo_pop) begin
                  state_d = ONE;
                  buf0_d  = fifo_data_out;
               end
            end
            ONE: begin
               if (fifo_pop && !take) begin
                  state_d = TWO;
                  buf1_d  = fifo_data_out;
               end else if (fifo_pop && take) begin
                  buf0_d  = fifo_data_out;
               end else if (take) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (take) begin
                  state_d = ONE;
                  buf0_d  = buf1_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
      valid_d = (state_d != EMPTY);
   end

`ifdef RISCV_FIFO_READER_STATS_EN
   // Accepted-word counter; wraps, cleared only by reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_count <= '0;
      end else if (take) begin
         out_count <= out_count + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_riscv_fifo_reader.sv
// Testbench for riscv_fifo_reader: emulated FIFO plus a queue-based reference
// model of the output stream, checked every cycle, with directed literal checks.
module tb_riscv_fifo_reader;

   logic        clk = 1'b0;
   logic        rstn;
   logic        flush;
   logic [31:0] fifo_data_out;
   logic        fifo_empty;
   logic        fifo_pop;
   logic        fifo_flush;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
`ifdef RISCV_FIFO_READER_STATS_EN
   logic [3:0]  out_count;
`endif

   always #5 clk = ~clk;

`ifdef RISCV_FIFO_READER_STATS_EN
   riscv_fifo_reader #(.DATA_W(32), .STAT_W(4)) dut (
`else
   riscv_fifo_reader #(.DATA_W(32)) dut (
`endif
      .clk(clk), .rstn(rstn), .flush(flush),
      .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
      .fifo_pop(fifo_pop), .fifo_flush(fifo_flush),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef RISCV_FIFO_READER_STATS_EN
      , .out_count(out_count)
`endif
   );

   logic [31:0] fq[$];   // emulated FIFO contents, head at index 0
   logic [31:0] mq[$];   // words the reader is expected to be holding, in order
   int          mcnt;    // expected accepted-word count
   int          n_cmp = 0;
   int          n_bad = 0;

   logic        s_pop, s_valid, s_flush;
   logic [31:0] s_data;
   logic [3:0]  s_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: present FIFO head, compare at negedge, advance model after the edge.
   task automatic cycle();
      logic        ep, ev, tk;
      logic [31:0] head;
      fifo_empty = (fq.size() == 0);
      if (fifo_empty) fifo_data_out = $urandom;
      else            fifo_data_out = fq[0];
      @(negedge clk);
      ep = !flush && (fq.size() != 0) && (mq.size() < 2);
      ev = (mq.size() != 0);
      s_pop = fifo_pop; s_valid = out_valid; s_data = out_data; s_flush = fifo_flush;
      chk("fifo_pop", 64'(s_pop), 64'(ep));
      chk("out_valid", 64'(s_valid), 64'(ev));
      chk("fifo_flush", 64'(s_flush), 64'(flush));
      if (ev) chk("out_data", 64'(s_data), 64'(mq[0]));
`ifdef RISCV_FIFO_READER_STATS_EN
      s_cnt = out_count;
      chk("out_count", 64'(s_cnt), 64'(mcnt % 16));
`else
      s_cnt = 4'd0;
`endif
      tk   = ev && out_ready;
      head = (fq.size() != 0) ? fq[0] : 32'd0;
      @(posedge clk);
      #1;
      if (tk) mcnt++;
      if (flush) begin
         mq.delete();
         fq.delete();
      end else begin
         if (tk) void'(mq.pop_front());
         if (ep) mq.push_back(head);
         if (s_pop && fq.size() != 0) void'(fq.pop_front());
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((fq.size() != 0 || mq.size() != 0) && n < budget) begin
         cycle();
         n++;
      end
      if (fq.size() != 0 || mq.size() != 0) chk("drain_timeout", 64'(n), 64'(budget + 1));
   endtask

   initial begin
      int pops;
      rstn = 1'b0; flush = 1'b0; out_ready = 1'b0;
      fifo_empty = 1'b1; fifo_data_out = '0; mcnt = 0;
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_fifo_pop", 64'(fifo_pop), 64'd0);
`ifdef RISCV_FIFO_READER_STATS_EN
      chk("rst_out_count", 64'(out_count), 64'd0);
`endif
      @(posedge clk); #1;
      rstn = 1'b1;

      // Stream 0x11,0x22,0x33 with out_ready=1.
      out_ready = 1'b1;
      fq.push_back(32'h11); fq.push_back(32'h22); fq.push_back(32'h33);
      cycle(); chk("stream_c0_pop", 64'(s_pop), 64'd1);
      cycle(); chk("stream_c1_data", 64'(s_data), 64'h11); chk("stream_c1_pop", 64'(s_pop), 64'd1);
      cycle(); chk("stream_c2_data", 64'(s_data), 64'h22); chk("stream_c2_pop", 64'(s_pop), 64'd1);
      cycle(); chk("stream_c3_data", 64'(s_data), 64'h33); chk("stream_c3_valid", 64'(s_valid), 64'd1);
      cycle(); chk("stream_c4_valid", 64'(s_valid), 64'd0);

      // Backpressure with 4 words queued.
      out_ready = 1'b0; pops = 0;
      fq.push_back(32'hA1); fq.push_back(32'hA2); fq.push_back(32'hA3); fq.push_back(32'hA4);
      for (int i = 0; i < 6; i++) begin
         cycle();
         pops += int'(s_pop);
      end
      chk("bp_pops", 64'(pops), 64'd2);
      chk("bp_pop_held", 64'(s_pop), 64'd0);
      chk("bp_data_held", 64'(s_data), 64'hA1);
      out_ready = 1'b1;
      cycle(); chk("bp_release_data", 64'(s_data), 64'hA1);
      cycle(); chk("bp_release_data2", 64'(s_data), 64'hA2);
      drain(20);
      cycle(); chk("bp_done_valid", 64'(s_valid), 64'd0);

      // Empty FIFO for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("empty_pop", 64'(s_pop), 64'd0);
         chk("empty_data_known", 64'((^s_data) !== 1'bx), 64'd1);
      end

      // Flush while two words are buffered and the FIFO is non-empty.
      out_ready = 1'b0;
      fq.push_back(32'hB1); fq.push_back(32'hB2); fq.push_back(32'hB3);
      cycle(); cycle(); cycle();
      flush = 1'b1;
      cycle();
      chk("flush_pop", 64'(s_pop), 64'd0);
      chk("flush_flush", 64'(s_flush), 64'd1);
      flush = 1'b0;
      cycle(); chk("flush_next_valid", 64'(s_valid), 64'd0);
      out_ready = 1'b1;
      fq.push_back(32'hC1);
      cycle(); cycle(); chk("flush_fresh_data", 64'(s_data), 64'hC1);
      drain(10);

      // Asynchronous reset mid-stream while two words are buffered.
      out_ready = 1'b0;
      fq.push_back(32'hD1); fq.push_back(32'hD2); fq.push_back(32'hD3);
      cycle(); cycle(); cycle();
      chk("pre_reset_two", 64'(mq.size()), 64'd2);
      #2 rstn = 1'b0;
      #1;
      chk("reset_mid_valid", 64'(out_valid), 64'd0);
      chk("reset_mid_data", 64'(out_data), 64'd0);
`ifdef RISCV_FIFO_READER_STATS_EN
      chk("reset_mid_count", 64'(out_count), 64'd0);
`endif
      mq.delete(); mcnt = 0;
      rstn = 1'b1;
      out_ready = 1'b1;
      drain(20);

      // Randomized traffic with varying backpressure and occasional flushes.
      for (int i = 0; i < 2000; i++) begin
         int rp;
         rp = (i / 250) % 4;
         if (fq.size() < 6 && ($urandom % 3) != 0) fq.push_back($urandom);
         case (rp)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom % 2) == 0;
            2: out_ready = ($urandom % 5) == 0;
            default: out_ready = ($urandom % 5) != 0;
         endcase
         flush = ($urandom % 40) == 0;
         cycle();
      end
      flush = 1'b0; out_ready = 1'b1;
      drain(30);

`ifdef RISCV_FIFO_READER_STATS_EN
      // Counter wrap with STAT_W=4: 17 accepted words, flush in between.
      rstn = 1'b0; #1;
      mq.delete(); fq.delete(); mcnt = 0;
      rstn = 1'b1;
      for (int i = 0; i < 9; i++) fq.push_back(32'h100 + 32'(i));
      drain(30);
      flush = 1'b1;
      cycle(); chk("stats_pre_flush", 64'(s_cnt), 64'd9);
      flush = 1'b0;
      cycle(); chk("stats_post_flush", 64'(s_cnt), 64'd9);
      for (int i = 0; i < 8; i++) fq.push_back(32'h200 + 32'(i));
      drain(30);
      cycle(); chk("stats_wrap", 64'(s_cnt), 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
